// File: rtl/dbus_pkg.sv
// Shared address map, STATUS bit layout and RAM window helper for dbus_responder.
package dbus_pkg;

  localparam logic [31:0] ADDR_TXDATA = 32'h0000_1000;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_1004;
  localparam logic [31:0] ADDR_CYCLES = 32'h0000_1008;

  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_BUSERR  = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 8;

  localparam logic [31:0] RAM_BASE = 32'h0000_0000;

  // First byte address past the RAM window.
  function automatic logic [31:0] ram_limit(input int unsigned words);
    return RAM_BASE + 32'(words * 4);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word; head is zero whenever the FIFO is empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_head,
  output logic             o_valid,
  output logic             o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd, r_wr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;
  logic             r_valid, r_full;

  logic             w_pop, w_push;
  logic [AW-1:0]    w_rd_next;
  logic [CW-1:0]    w_count_next;
  logic [WIDTH-1:0] w_head_next;

  assign w_pop  = i_pop && r_valid;
  assign w_push = i_push && (!r_full || w_pop);

  // Next head: the incoming word when it lands in an otherwise empty queue.
  always_comb begin
    w_rd_next    = w_pop ? r_rd + AW'(1) : r_rd;
    w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    w_head_next  = '0;
    if (w_count_next != '0) begin
      if (w_push && ((r_count - CW'(w_pop)) == '0))
        w_head_next = i_din;
      else
        w_head_next = r_mem[w_rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_head  <= '0;
      r_valid <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      r_rd    <= w_rd_next;
      r_wr    <= w_push ? r_wr + AW'(1) : r_wr;
      r_count <= w_count_next;
      r_head  <= w_head_next;
      r_valid <= (w_count_next != '0);
      r_full  <= (w_count_next == CW'(DEPTH));
    end
  end

  assign o_head  = r_head;
  assign o_valid = r_valid;
  assign o_full  = r_full;
  assign o_count = r_count;

endmodule

// File: rtl/dbus_responder.sv
// Data-side responder for the single-cycle core: word RAM plus TX FIFO, STATUS and CYCLES registers.
module dbus_responder
  import dbus_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  TxData,
  output logic        TxValid,
  input  logic        TxReady
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned CW     = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] RAM_LIMIT = ram_limit(RAM_WORDS);

  logic [31:0] r_ram [RAM_WORDS];
  logic [31:0] r_cycles;
  logic        r_bus_err, r_ovf;

  logic          w_in_ram, w_is_tx, w_is_status, w_is_cycles, w_is_other;
  logic          w_wr, w_tx_pop, w_tx_wr, w_ovf_set, w_err_set;
  logic          w_full;
  logic [CW-1:0] w_count;
  logic [31:0]   w_status;

  assign w_in_ram    = (DataAdr < RAM_LIMIT);
  assign w_is_tx     = (DataAdr[31:2] == ADDR_TXDATA[31:2]);
  assign w_is_status = (DataAdr[31:2] == ADDR_STATUS[31:2]);
  assign w_is_cycles = (DataAdr[31:2] == ADDR_CYCLES[31:2]);
  assign w_is_other  = !(w_in_ram || w_is_tx || w_is_status || w_is_cycles);

  assign w_wr      = MemWrite && !reset;
  assign w_tx_pop  = TxValid && TxReady;
  assign w_tx_wr   = w_wr && w_is_tx;
  assign w_ovf_set = w_tx_wr && w_full && !w_tx_pop;
  assign w_err_set = w_wr && w_is_other;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .i_rst   (reset),
    .i_push  (w_tx_wr),
    .i_pop   (TxReady),
    .i_din   (WriteData[7:0]),
    .o_head  (TxData),
    .o_valid (TxValid),
    .o_full  (w_full),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (w_wr && w_in_ram) r_ram[DataAdr[RAM_AW+1:2]] <= WriteData;
  end

  // Sticky flags: a set event in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycles  <= '0;
      r_bus_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_cycles <= (w_wr && w_is_cycles) ? WriteData : r_cycles + 32'd1;
      if (w_err_set)
        r_bus_err <= 1'b1;
      else if (w_wr && w_is_status && WriteData[ST_BUSERR])
        r_bus_err <= 1'b0;
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (w_wr && w_is_status && WriteData[ST_OVF])
        r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_status                     = '0;
    w_status[ST_FULL]            = w_full;
    w_status[ST_EMPTY]           = !TxValid;
    w_status[ST_BUSERR]          = r_bus_err;
    w_status[ST_OVF]             = r_ovf;
    w_status[ST_CNT_LSB +: 8]    = 8'(w_count);
  end

  always_comb begin
    ReadData = '0;
    if (w_in_ram)         ReadData = r_ram[DataAdr[RAM_AW+1:2]];
    else if (w_is_status) ReadData = w_status;
    else if (w_is_cycles) ReadData = r_cycles;
  end

endmodule

// File: tb/tb_dbus_responder.sv
// Directed self-checking bench for dbus_responder with hand-computed expectations.
module tb_dbus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] A_TX  = 32'h0000_1000;
  localparam logic [31:0] A_ST  = 32'h0000_1004;
  localparam logic [31:0] A_CYC = 32'h0000_1008;

  dbus_responder #(.RAM_WORDS(256), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .TxData    (TxData),
    .TxValid   (TxValid),
    .TxReady   (TxReady)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    tick();
    MemWrite  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    MemWrite = 1'b0;
    DataAdr  = a;
    #1;
    d = ReadData;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; TxReady = 1'b0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (TxValid !== 1'b0) begin errors++; $display("FAIL reset_txvalid got=%b exp=0", TxValid); end
    checks++; if (TxData !== 8'h00) begin errors++; $display("FAIL reset_txdata got=%h exp=00", TxData); end
    rd(A_ST, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL reset_status got=%h exp=00000002", v); end
    rd(A_CYC, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_cycles got=%h exp=00000000", v); end
  endtask

  task automatic test_ram();
    logic [31:0] v;
    wr(32'h10, 32'hDEADBEEF);
    rd(32'h12, v);
    checks++; if (v !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_0x12 got=%h exp=deadbeef", v); end
    wr(32'h14, 32'h1);
    rd(32'h14, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL ram_0x14 got=%h exp=00000001", v); end
    rd(32'h10, v);
    checks++; if (v !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_0x10_kept got=%h exp=deadbeef", v); end
    rd(A_TX, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL txdata_read got=%h exp=00000000", v); end
  endtask

  task automatic test_fifo();
    logic [31:0] v;
    logic [7:0]  exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    TxReady = 1'b0;
    for (int i = 0; i < 3; i++) wr(A_TX, {24'h0, exp_b[i]});
    rd(A_ST, v);
    checks++; if (v !== 32'h0000_0300) begin errors++; $display("FAIL fifo_status3 got=%h exp=00000300", v); end
    checks++; if (TxData !== 8'h41 || TxValid !== 1'b1) begin errors++; $display("FAIL fifo_hold got=%h/%b exp=41/1", TxData, TxValid); end
    TxReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (TxValid !== 1'b1 || TxData !== exp_b[i]) begin
        errors++; $display("FAIL fifo_byte%0d got=%h/%b exp=%h/1", i, TxData, TxValid, exp_b[i]);
      end
      tick();
    end
    TxReady = 1'b0;
    checks++; if (TxValid !== 1'b0) begin errors++; $display("FAIL fifo_drained got=%b exp=0", TxValid); end
    rd(A_ST, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL fifo_status_empty got=%h exp=00000002", v); end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    TxReady = 1'b0;
    for (int i = 0; i < 9; i++) wr(A_TX, 32'h10 + 32'(i));
    rd(A_ST, v);
    checks++; if (v !== 32'h0000_0809) begin errors++; $display("FAIL ovf_status got=%h exp=00000809", v); end
    wr(A_ST, 32'h8);
    rd(A_ST, v);
    checks++; if (v !== 32'h0000_0801) begin errors++; $display("FAIL ovf_clear got=%h exp=00000801", v); end
    TxReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (TxValid !== 1'b1 || TxData !== 8'(8'h10 + i)) begin
        errors++; $display("FAIL ovf_byte%0d got=%h/%b exp=%h/1", i, TxData, TxValid, 8'(8'h10 + i));
      end
      tick();
    end
    TxReady = 1'b0;
    checks++; if (TxValid !== 1'b0) begin errors++; $display("FAIL ovf_ninth_dropped got=%b/%h exp=0", TxValid, TxData); end
  endtask

  task automatic test_full_pop();
    logic [31:0] v;
    logic [7:0]  e;
    TxReady = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_TX, 32'h20 + 32'(i));
    TxReady = 1'b1;
    wr(A_TX, 32'h55);
    TxReady = 1'b0;
    rd(A_ST, v);
    checks++; if (v !== 32'h0000_0801) begin errors++; $display("FAIL fullpop_status got=%h exp=00000801", v); end
    TxReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = (i == 7) ? 8'h55 : 8'(8'h21 + i);
      checks++;
      if (TxValid !== 1'b1 || TxData !== e) begin
        errors++; $display("FAIL fullpop_byte%0d got=%h/%b exp=%h/1", i, TxData, TxValid, e);
      end
      tick();
    end
    TxReady = 1'b0;
    checks++; if (TxValid !== 1'b0) begin errors++; $display("FAIL fullpop_empty got=%b exp=0", TxValid); end
  endtask

  task automatic test_counter();
    logic [31:0] v;
    wr(A_CYC, 32'hFFFF_FFFE);
    rd(A_CYC, v);
    checks++; if (v !== 32'hFFFF_FFFE) begin errors++; $display("FAIL cyc_load got=%h exp=fffffffe", v); end
    tick();
    rd(A_CYC, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cyc_inc got=%h exp=ffffffff", v); end
    tick();
    rd(A_CYC, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL cyc_wrap got=%h exp=00000000", v); end
  endtask

  task automatic test_bus_err();
    logic [31:0] v;
    wr(32'h0, 32'hCAFE_F00D);
    rd(32'h2000, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL err_read_noset got=%h exp=00000000", v); end
    rd(A_ST, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL err_read_status got=%h exp=00000002", v); end
    wr(32'h2000, 32'h1234_5678);
    rd(A_ST, v);
    checks++; if (v !== 32'h6) begin errors++; $display("FAIL err_status got=%h exp=00000006", v); end
    rd(32'h0, v);
    checks++; if (v !== 32'hCAFE_F00D) begin errors++; $display("FAIL err_ram_kept got=%h exp=cafef00d", v); end
    wr(A_ST, 32'h4);
    rd(A_ST, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL err_clear got=%h exp=00000002", v); end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] v;
    TxReady = 1'b0;
    for (int i = 0; i < 4; i++) wr(A_TX, 32'h60 + 32'(i));
    rd(A_ST, v);
    checks++; if (v !== 32'h0000_0400) begin errors++; $display("FAIL mid_status4 got=%h exp=00000400", v); end
    reset = 1'b1;
    wr(A_TX, 32'h77);
    checks++; if (TxValid !== 1'b0 || TxData !== 8'h00) begin errors++; $display("FAIL mid_txvalid got=%b/%h exp=0/00", TxValid, TxData); end
    reset = 1'b0;
    rd(A_ST, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL mid_status got=%h exp=00000002", v); end
    rd(A_CYC, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_cycles got=%h exp=00000000", v); end
    tick();
    checks++; if (TxValid !== 1'b0) begin errors++; $display("FAIL mid_write_in_reset got=%b exp=0", TxValid); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_fifo();
    test_overflow();
    test_full_pop();
    test_counter();
    test_bus_err();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
